// File: rtl/tlul_a_arbiter_3to1.sv
// tlul_a_arbiter_3to1
//   Puts three TL-UL masters onto one TL-UL slave port. The A channel is
//   granted round-robin, one beat per grant. Each granted master index goes
//   into an in-order outstanding FIFO, and the FIFO head steers the D channel
//   back to the master that owns the response.
//
// Optional build macro:
//   TLUL_ARB_PERF_EN - adds grant_count: a saturating 16-bit A-handshake
//                      counter per master, packed as master i at [i*16 +: 16].
//
// Ports (master i uses slice [i*W +: W] of every packed bus):
//   clk, reset                    clock, synchronous active-high reset
//   master_a_valid/ready [3]      per-master A handshake
//   master_a_address/data/mask/opcode/size   packed A fields
//   slave_a_valid/ready           A handshake to the slave
//   slave_a_address/data/mask/opcode/size    A fields of the granted master
//                                 (zero when no grant is held)
//   slave_d_valid/ready           D handshake from the slave
//   slave_d_data/opcode/size/error           D fields from the slave
//   master_d_valid/ready [3]      per-master D handshake
//   master_d_data/opcode/size/error          D fields copied to all slices
//   unexpected_d                  sticky: D valid seen with no outstanding request
//   grant_count                   (TLUL_ARB_PERF_EN only) per-master grant counters
//   dbg_state                     1 = ARB_BUSY, 0 = ARB_IDLE
//   dbg_grant_idx                 registered grant index
//   dbg_count                     outstanding FIFO occupancy
//
// Handshake rule on every channel: a beat moves on a cycle where valid and
// ready are both high. valid does not depend on ready. ready toward a master
// is only a pass-through of the matching slave ready for the selected
// master, so no beat can complete for a master that is not selected.
module tlul_a_arbiter_3to1 #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MASK_WIDTH      = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH      = 3,
  parameter int OPCODE_WIDTH    = 3,
  parameter int MAX_OUTSTANDING = 4,
  localparam int PTR_W          = $clog2(MAX_OUTSTANDING),
  localparam int CNT_W          = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                master_a_valid,
  output logic [2:0]                master_a_ready,
  input  logic [3*ADDR_WIDTH-1:0]   master_a_address,
  input  logic [3*DATA_WIDTH-1:0]   master_a_data,
  input  logic [3*MASK_WIDTH-1:0]   master_a_mask,
  input  logic [3*OPCODE_WIDTH-1:0] master_a_opcode,
  input  logic [3*SIZE_WIDTH-1:0]   master_a_size,
  output logic                      slave_a_valid,
  input  logic                      slave_a_ready,
  output logic [ADDR_WIDTH-1:0]     slave_a_address,
  output logic [DATA_WIDTH-1:0]     slave_a_data,
  output logic [MASK_WIDTH-1:0]     slave_a_mask,
  output logic [OPCODE_WIDTH-1:0]   slave_a_opcode,
  output logic [SIZE_WIDTH-1:0]     slave_a_size,
  input  logic                      slave_d_valid,
  output logic                      slave_d_ready,
  input  logic [DATA_WIDTH-1:0]     slave_d_data,
  input  logic [OPCODE_WIDTH-1:0]   slave_d_opcode,
  input  logic [SIZE_WIDTH-1:0]     slave_d_size,
  input  logic                      slave_d_error,
  output logic [2:0]                master_d_valid,
  input  logic [2:0]                master_d_ready,
  output logic [3*DATA_WIDTH-1:0]   master_d_data,
  output logic [3*OPCODE_WIDTH-1:0] master_d_opcode,
  output logic [3*SIZE_WIDTH-1:0]   master_d_size,
  output logic [2:0]                master_d_error,
  output logic                      unexpected_d,
`ifdef TLUL_ARB_PERF_EN
  output logic [3*16-1:0]           grant_count,
`endif
  output logic                      dbg_state,
  output logic [1:0]                dbg_grant_idx,
  output logic [CNT_W-1:0]          dbg_count
);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic [CNT_W-1:0] FIFO_DEPTH = CNT_W'(MAX_OUTSTANDING);

  arb_state_t         state, state_next;
  logic [1:0]         grant_idx;
  logic [1:0]         last_grant;
  logic               arb_take;
  logic [1:0]         rr_idx;
  logic               a_busy;
  logic               a_fire;
  logic               d_fire;

  logic [1:0]         fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty, fifo_full;
  logic [1:0]         fifo_head;

  logic [ADDR_WIDTH-1:0]   a_addr [3];
  logic [DATA_WIDTH-1:0]   a_data [3];
  logic [MASK_WIDTH-1:0]   a_mask [3];
  logic [OPCODE_WIDTH-1:0] a_opcode [3];
  logic [SIZE_WIDTH-1:0]   a_size [3];

  // Round-robin pick: first valid master after last_grant, wrapping mod 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] valid, input logic [1:0] last);
    logic [1:0] c0, c1, c2;
    logic [1:0] pick;
    case (last)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (valid[c0])      pick = c0;
    else if (valid[c1]) pick = c1;
    else if (valid[c2]) pick = c2;
    else                pick = 2'd0;
    return pick;
  endfunction

  assign rr_idx     = rr_pick(master_a_valid, last_grant);
  assign a_busy     = (state == ARB_BUSY);
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FIFO_DEPTH);
  assign fifo_head  = fifo_mem[rd_ptr];

  // ---------------- A channel ----------------
  assign slave_a_valid   = a_busy && master_a_valid[grant_idx];
  assign a_fire          = slave_a_valid && slave_a_ready;
  assign slave_a_address = a_busy ? a_addr[grant_idx]   : '0;
  assign slave_a_data    = a_busy ? a_data[grant_idx]   : '0;
  assign slave_a_mask    = a_busy ? a_mask[grant_idx]   : '0;
  assign slave_a_opcode  = a_busy ? a_opcode[grant_idx] : '0;
  assign slave_a_size    = a_busy ? a_size[grant_idx]   : '0;

  // ---------------- D channel ----------------
  // An empty FIFO means nobody owns the response: it is never acknowledged,
  // only flagged through unexpected_d.
  assign slave_d_ready = !fifo_empty && master_d_ready[fifo_head];
  assign d_fire        = slave_d_valid && slave_d_ready;

  assign master_d_data   = {3{slave_d_data}};
  assign master_d_opcode = {3{slave_d_opcode}};
  assign master_d_size   = {3{slave_d_size}};
  assign master_d_error  = {3{slave_d_error}};

  for (genvar i = 0; i < 3; i++) begin : g_slice
    assign a_addr[i]   = master_a_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign a_data[i]   = master_a_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign a_mask[i]   = master_a_mask[i*MASK_WIDTH +: MASK_WIDTH];
    assign a_opcode[i] = master_a_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
    assign a_size[i]   = master_a_size[i*SIZE_WIDTH +: SIZE_WIDTH];

    assign master_a_ready[i] = a_busy && (grant_idx == 2'(i)) && slave_a_ready;
    assign master_d_valid[i] = !fifo_empty && (fifo_head == 2'(i)) && slave_d_valid;
  end

  // ---------------- FSM ----------------
  // A grant is held until its beat completes. The only other way out of
  // BUSY is the granted master withdrawing valid, which drops the grant
  // without recording anything.
  always_comb begin
    state_next = state;
    arb_take   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|master_a_valid && !fifo_full) begin
          state_next = ARB_BUSY;
          arb_take   = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (a_fire || !master_a_valid[grant_idx]) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ARB_IDLE;
      grant_idx    <= 2'd0;
      last_grant   <= 2'd2;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      unexpected_d <= 1'b0;
    end else begin
      state <= state_next;
      if (arb_take) grant_idx <= rr_idx;
      if (a_fire) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        last_grant <= grant_idx;
      end
      if (d_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      // A push and a pop in the same cycle cancel out.
      case ({a_fire, d_fire})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (slave_d_valid && fifo_empty) unexpected_d <= 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  // Entering BUSY requires a free slot, so a push never overwrites one.
  always_ff @(posedge clk) begin
    if (a_fire) fifo_mem[wr_ptr] <= grant_idx;
  end

`ifdef TLUL_ARB_PERF_EN
  for (genvar i = 0; i < 3; i++) begin : g_perf
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= 16'd0;
      end else if (a_fire && (grant_idx == 2'(i)) && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign grant_count[i*16 +: 16] = cnt_q;
  end
`endif

  assign dbg_state     = (state == ARB_BUSY);
  assign dbg_grant_idx = grant_idx;
  assign dbg_count     = fifo_count;

endmodule

// File: tb/tb_tlul_a_arbiter_3to1.sv
// Testbench for tlul_a_arbiter_3to1 (default parameters).
// Inputs are driven 1 time unit after the rising clock edge. Outputs are
// sampled 2 time units after that, which is well away from the next edge.
module tb_tlul_a_arbiter_3to1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0]  master_a_valid, master_a_ready;
  logic [95:0] master_a_address, master_a_data;
  logic [11:0] master_a_mask;
  logic [8:0]  master_a_opcode, master_a_size;
  logic        slave_a_valid, slave_a_ready;
  logic [31:0] slave_a_address, slave_a_data;
  logic [3:0]  slave_a_mask;
  logic [2:0]  slave_a_opcode, slave_a_size;
  logic        slave_d_valid, slave_d_ready;
  logic [31:0] slave_d_data;
  logic [2:0]  slave_d_opcode, slave_d_size;
  logic        slave_d_error;
  logic [2:0]  master_d_valid, master_d_ready;
  logic [95:0] master_d_data;
  logic [8:0]  master_d_opcode, master_d_size;
  logic [2:0]  master_d_error;
  logic        unexpected_d;
`ifdef TLUL_ARB_PERF_EN
  logic [47:0] grant_count;
`endif
  logic        dbg_state;
  logic [1:0]  dbg_grant_idx;
  logic [2:0]  dbg_count;

  tlul_a_arbiter_3to1 dut (
    .clk(clk), .reset(reset),
    .master_a_valid(master_a_valid), .master_a_ready(master_a_ready),
    .master_a_address(master_a_address), .master_a_data(master_a_data),
    .master_a_mask(master_a_mask), .master_a_opcode(master_a_opcode),
    .master_a_size(master_a_size),
    .slave_a_valid(slave_a_valid), .slave_a_ready(slave_a_ready),
    .slave_a_address(slave_a_address), .slave_a_data(slave_a_data),
    .slave_a_mask(slave_a_mask), .slave_a_opcode(slave_a_opcode),
    .slave_a_size(slave_a_size),
    .slave_d_valid(slave_d_valid), .slave_d_ready(slave_d_ready),
    .slave_d_data(slave_d_data), .slave_d_opcode(slave_d_opcode),
    .slave_d_size(slave_d_size), .slave_d_error(slave_d_error),
    .master_d_valid(master_d_valid), .master_d_ready(master_d_ready),
    .master_d_data(master_d_data), .master_d_opcode(master_d_opcode),
    .master_d_size(master_d_size), .master_d_error(master_d_error),
    .unexpected_d(unexpected_d),
`ifdef TLUL_ARB_PERF_EN
    .grant_count(grant_count),
`endif
    .dbg_state(dbg_state), .dbg_grant_idx(dbg_grant_idx), .dbg_count(dbg_count)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic rst, input logic [2:0] mv, input logic sar, input logic sdv);
    reset          = rst;
    master_a_valid = mv;
    slave_a_ready  = sar;
    slave_d_valid  = sdv;
  endtask

  task automatic do_reset();
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    master_d_ready = 3'b111;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [2:0]  mv;
    logic        sar;
    logic        sdv;
    logic [2:0]  e_mar;
    logic        e_sav;
    logic [31:0] e_addr;
    logic [1:0]  e_gidx;
    logic        e_busy;
    logic [2:0]  e_cnt;
    logic [2:0]  e_mdv;
    logic        e_sdr;
    logic        e_unx;
    logic        chk_data;
  } vec_t;

  vec_t vecs[12];

  localparam logic [31:0] ADDR0 = 32'h0000_0A00;
  localparam logic [31:0] ADDR1 = 32'h0000_0100;
  localparam logic [31:0] ADDR2 = 32'h0000_0200;

  initial begin
    master_a_address = {ADDR2, ADDR1, ADDR0};
    master_a_data    = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
    master_a_mask    = {4'hF, 4'hF, 4'hF};
    master_a_opcode  = {3'd0, 3'd4, 3'd4};
    master_a_size    = {3'd2, 3'd2, 3'd2};
    slave_d_data     = 32'hDEAD_BEEF;
    slave_d_opcode   = 3'd1;
    slave_d_size     = 3'd2;
    slave_d_error    = 1'b0;
    master_d_ready   = 3'b111;

    //           rst  mv      sar   sdv   | mar     sav   addr   gidx  busy  cnt   mdv     sdr   unx   data
    vecs[0]  = '{1'b1, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0,  2'd0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'b010, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0,  2'd0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, ADDR1,  2'd1, 1'b1, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0,  2'd1, 1'b0, 3'd1, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 32'h0,  2'd1, 1'b0, 3'd1, 3'b010, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0,  2'd1, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
    // master 0 granted, then withdraws valid before the beat completes
    vecs[6]  = '{1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,  2'd1, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, ADDR0,  2'd0, 1'b1, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,  2'd0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
    // D valid with nothing outstanding
    vecs[9]  = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0,  2'd0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,  2'd0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 3'b100, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0,  2'd0, 1'b0, 3'd0, 3'b000, 1'b0, 1'b1, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [2:0] exp_mar;
    logic [1:0] rr_order [3];
    rr_order[0] = 2'd0;
    rr_order[1] = 2'd1;
    rr_order[2] = 2'd2;
    #1;
    do_reset();

    // Table: single master Get, response routing, dropped grant, stray D
    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].rst, vecs[v].mv, vecs[v].sar, vecs[v].sdv);
      settle();
      check($sformatf("v%0d master_a_ready", v), master_a_ready, vecs[v].e_mar);
      check($sformatf("v%0d slave_a_valid", v), slave_a_valid, vecs[v].e_sav);
      check($sformatf("v%0d slave_a_address", v), slave_a_address, vecs[v].e_addr);
      check($sformatf("v%0d grant_idx", v), dbg_grant_idx, vecs[v].e_gidx);
      check($sformatf("v%0d busy", v), dbg_state, vecs[v].e_busy);
      check($sformatf("v%0d count", v), dbg_count, vecs[v].e_cnt);
      check($sformatf("v%0d master_d_valid", v), master_d_valid, vecs[v].e_mdv);
      check($sformatf("v%0d slave_d_ready", v), slave_d_ready, vecs[v].e_sdr);
      check($sformatf("v%0d unexpected_d", v), unexpected_d, vecs[v].e_unx);
      if (vecs[v].chk_data) check($sformatf("v%0d d_data slice1", v), master_d_data[63:32], 32'hDEAD_BEEF);
      tick();
    end

    // Round robin with all masters valid and the slave always ready
    do_reset();
    drive(1'b0, 3'b111, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) begin
      settle();
      exp_mar = (c % 2 == 1) ? (3'b001 << rr_order[(c / 2) % 3]) : 3'b000;
      check($sformatf("rr c%0d master_a_ready", c), master_a_ready, exp_mar);
      tick();
    end
`ifdef TLUL_ARB_PERF_EN
    check("rr grant_count", grant_count, {16'd2, 16'd2, 16'd2});
`endif

    // Slave stalls master 2 for five cycles
    do_reset();
    drive(1'b0, 3'b100, 1'b0, 1'b0);
    settle();
    check("stall idle busy", dbg_state, 1'b0);
    tick();
    for (int c = 1; c <= 5; c++) begin
      drive(1'b0, 3'b111, 1'b0, 1'b0);
      settle();
      check($sformatf("stall c%0d master_a_ready", c), master_a_ready, 3'b000);
      check($sformatf("stall c%0d grant_idx", c), dbg_grant_idx, 2'd2);
      check($sformatf("stall c%0d slave_a_valid", c), slave_a_valid, 1'b1);
      if (c == 1) begin
        check("stall slave_a_data", slave_a_data, 32'hD000_0002);
        check("stall slave_a_opcode", slave_a_opcode, 3'd0);
      end
      tick();
    end
    drive(1'b0, 3'b111, 1'b1, 1'b0);
    settle();
    check("stall release master_a_ready", master_a_ready, 3'b100);
    tick();
    settle();
    check("stall after busy", dbg_state, 1'b0);
    check("stall after count", dbg_count, 3'd1);
    tick();
    settle();
    check("stall next busy", dbg_state, 1'b1);
    check("stall next grant_idx", dbg_grant_idx, 2'd0);

    // Fill the FIFO with D held off, then drain in grant order
    do_reset();
    drive(1'b0, 3'b111, 1'b1, 1'b0);
    exp_q = {};
    for (int c = 0; c < 8; c++) tick();
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    for (int c = 8; c <= 10; c++) begin
      settle();
      check($sformatf("full c%0d busy", c), dbg_state, 1'b0);
      check($sformatf("full c%0d count", c), dbg_count, 3'd4);
      check($sformatf("full c%0d master_a_ready", c), master_a_ready, 3'b000);
      tick();
    end
    drive(1'b0, 3'b111, 1'b1, 1'b1);
    for (int c = 11; c <= 14; c++) begin
      logic [1:0] exp_owner;
      settle();
      exp_owner = exp_q.pop_front();
      check($sformatf("drain c%0d master_d_valid", c), master_d_valid, 3'b001 << exp_owner);
      check($sformatf("drain c%0d slave_d_ready", c), slave_d_ready, 1'b1);
      if (c == 12) begin
        check("drain c12 busy", dbg_state, 1'b0);
        check("drain c12 count", dbg_count, 3'd3);
      end
      if (c == 13) begin
        check("drain c13 busy", dbg_state, 1'b1);
        check("drain c13 grant_idx", dbg_grant_idx, 2'd1);
        check("drain c13 count", dbg_count, 3'd2);
        exp_q.push_back(2'd1);
      end
      if (c == 14) check("push+pop count", dbg_count, 3'd2);
      tick();
    end
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    tick();

    // Reset while BUSY with two outstanding
    do_reset();
    drive(1'b0, 3'b111, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    drive(1'b1, 3'b111, 1'b0, 1'b0);
    settle();
    check("rst pre busy", dbg_state, 1'b1);
    check("rst pre count", dbg_count, 3'd2);
    check("rst pre grant_idx", dbg_grant_idx, 2'd2);
    tick();
    drive(1'b0, 3'b111, 1'b1, 1'b1);
    settle();
    check("rst master_a_ready", master_a_ready, 3'b000);
    check("rst slave_a_valid", slave_a_valid, 1'b0);
    check("rst slave_a_address", slave_a_address, 32'h0);
    check("rst master_d_valid", master_d_valid, 3'b000);
    check("rst slave_d_ready", slave_d_ready, 1'b0);
    check("rst unexpected_d", unexpected_d, 1'b0);
    check("rst count", dbg_count, 3'd0);
    check("rst busy", dbg_state, 1'b0);
`ifdef TLUL_ARB_PERF_EN
    check("rst grant_count", grant_count, 48'h0);
`endif
    tick();
    drive(1'b0, 3'b111, 1'b1, 1'b0);
    settle();
    check("rst first grant busy", dbg_state, 1'b1);
    check("rst first grant idx", dbg_grant_idx, 2'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tlul_a_arbiter_3to1.md
Name: tlul_a_arbiter_3to1

Overview:
- Sequences three TL-UL masters onto one shared TL-UL slave port.
- Round-robin arbitration on the A channel, one beat per grant.
- An in-order outstanding-request FIFO records the granted master index and routes each D-channel response back to it.
- Sits between the master ports and the slave in the 3M-1S interconnect. Bus packing matches the interconnect monitor: master i occupies slice [i*W +: W].

Parameters:
- DATA_WIDTH, 32, A/D data width
- ADDR_WIDTH, 32, A address width
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width
- SIZE_WIDTH, 3, size field width
- OPCODE_WIDTH, 3, opcode field width
- MAX_OUTSTANDING, 4, outstanding-FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- master_a_valid  in  3  per-master A valid
- master_a_ready  out  3  per-master A ready
- master_a_address  in  3*ADDR_WIDTH  packed addresses
- master_a_data  in  3*DATA_WIDTH  packed write data
- master_a_mask  in  3*MASK_WIDTH  packed masks
- master_a_opcode  in  3*OPCODE_WIDTH  packed opcodes
- master_a_size  in  3*SIZE_WIDTH  packed sizes
- slave_a_valid  out  1  A valid to slave
- slave_a_ready  in  1  slave A ready
- slave_a_address/data/mask/opcode/size  out  ADDR/DATA/MASK/OPCODE/SIZE_WIDTH  muxed fields of granted master
- slave_d_valid  in  1  slave D valid
- slave_d_ready  out  1  D ready to slave
- slave_d_data/opcode/size/error  in  DATA/OPCODE/SIZE_WIDTH/1  slave D fields
- master_d_valid  out  3  per-master D valid
- master_d_ready  in  3  per-master D ready
- master_d_data/opcode/size/error  out  3*DATA/3*OPCODE/3*SIZE_WIDTH/3  D fields replicated to all three slices
- unexpected_d  out  1  sticky: slave_d_valid seen with FIFO empty

Behaviour:
- Reset (sync, active-high, overrides everything including mid-transfer):
  - state=ARB_IDLE, grant_idx=0, last_grant=2, FIFO count/pointers=0, unexpected_d=0.
  - All valid/ready outputs 0; muxed A fields 0 when not BUSY.
- FSM ARB_IDLE:
  - If any master_a_valid=1 and FIFO count<MAX_OUTSTANDING, select winner by round-robin: first valid index scanning last_grant+1, +2, +3 mod 3.
  - Register the winner in grant_idx and move to ARB_BUSY.
  - No ready asserted in IDLE.
- FSM ARB_BUSY:
  - slave_a_valid=master_a_valid[grant_idx]; slave_a_* fields = slice grant_idx (combinational).
  - master_a_ready[grant_idx]=slave_a_ready; other ready bits=0.
  - On slave_a_valid&&slave_a_ready: push grant_idx into FIFO, last_grant<=grant_idx, next state ARB_IDLE.
  - Grant is held (no re-arbitration) until the handshake completes.
  - If the granted master drops valid before handshake (protocol violation), return to IDLE without push.
- Throughput: at most one A beat per 2 cycles; arbitration latency 1 cycle from valid to grant.
- Full: FIFO full blocks IDLE→BUSY. Entering BUSY guarantees one free slot.
- D routing, FIFO non-empty, head=h:
  - master_d_valid[h]=slave_d_valid; other valid bits 0.
  - slave_d_ready=master_d_ready[h].
  - Pop on slave_d_valid&&slave_d_ready.
- D routing, FIFO empty:
  - master_d_valid=0, slave_d_ready=0.
  - If slave_d_valid=1, set unexpected_d (cleared only by reset).
- Simultaneous push and pop: both occur, count unchanged. Pointers wrap mod MAX_OUTSTANDING.
- D routing is purely combinational (0-cycle). Responses are delivered strictly in grant order.

Optional Feature:
- TLUL_ARB_PERF_EN defined:
  - Adds output grant_count (3*16 bits): per-master 16-bit counters of A handshakes.
  - Counters saturate at 0xFFFF and reset to 0.
- Not defined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Single master 1 issues Get addr 0x100, slave_a_ready=1:
  - grant one cycle after valid; slave_a_address=0x100; FIFO count 1.
  - slave D response data 0xDEADBEEF → master_d_valid=3'b010, data visible in slice 1; count returns to 0.
- All three masters valid continuously, slave always ready:
  - grant order 0,1,2,0,1,2; one handshake every 2 cycles.
- Slave_a_ready low for 5 cycles while master 2 granted:
  - master_a_ready stays 0; grant_idx stays 2; no other master's ready asserted.
  - Handshake on cycle 6; next grant goes to master 0.
- Issue 4 requests (0,1,2,0) with D held off:
  - 5th request not granted while count=4.
  - Responses then route to masters 0,1,2,0 in order; grants resume after the first pop.
- Push and pop in the same cycle at count=2 → count stays 2.
  - slave_d_valid with FIFO empty → slave_d_ready=0, unexpected_d=1.
- Assert reset while BUSY with 2 outstanding:
  - all outputs 0 next cycle, count 0, first subsequent grant to master 0.
  - With TLUL_ARB_PERF_EN, counters read 0 after reset.
